// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with 2-flop input synchroniser and centre sampling.
// Define UART_RX_PARITY_EN for 8-E-1 framing with a parity_err output.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            valid      <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rxs)
                        state <= ST_START;
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                        state   <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        // even parity: data plus parity bit must hold an even count of ones
                        par_bad <= ^{shift, rxs};
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end else begin
                            state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                data  <= shift;
                                valid <= 1'b1;
                            end
`else
                            data  <= shift;
                            valid <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // a line held low must go high before another start can be seen
                    cnt <= '0;
                    if (rxs)
                        state <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for the 8-N-1 link, the receive counterpart of the team's 9600-baud transmit timing. Takes the asynchronous serial line, synchronises it, detects and validates the start bit, samples each bit at its centre with an internal bit-period counter, and presents the assembled byte with a one-cycle valid strobe. Sits between the board RX pin and the byte-level consumer logic in the `clk` domain.

## Interface

**Parameters**

- `CLKS_PER_BIT`, default 5208: clocks per bit (50 MHz / 9600). Must be ≥ 4. `HALF = CLKS_PER_BIT/2`, integer division.

**Ports** (clock and reset first)

- `clk`, input, 1: clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `rx`, input, 1: asynchronous serial line, idle high.
- `data`, output, 8: last correctly framed byte; holds until the next good frame.
- `valid`, output, 1: one-cycle pulse; `data` is new this cycle.
- `frame_err`, output, 1: one-cycle pulse; stop bit sampled low.
- `parity_err`, output, 1: one-cycle pulse; exists only with `UART_RX_PARITY_EN`.
- `busy`, output, 1: high in every state except IDLE.

## Operation

- **Synchroniser.** `rx` always passes through a 2-flop synchroniser. `rxs` is the second flop, and all FSM decisions use `rxs`. Both flops reset to 1.
- **Counter.** The bit counter is `$clog2(CLKS_PER_BIT)` bits wide. It clears on every state change and never wraps within a state.
- **States:** IDLE, START, DATA, [PARITY], STOP, BREAK.
  - **IDLE:** when `rxs == 0`, go to START.
  - **START:** count to `HALF-1`, then sample `rxs`.
    - 0: go to DATA; bit index = 0.
    - 1: false start; return to IDLE with no output pulse.
  - **DATA:** count to `CLKS_PER_BIT-1`, then sample. Shift right into the 8-bit shift register, LSB first (sample enters bit 7).
    - After bit index 7, go to PARITY (if enabled) or to STOP.
  - **PARITY:** sample after `CLKS_PER_BIT` clocks and compare against the even parity of the shift register. Always go to STOP; the error flag is held until STOP.
  - **STOP:** sample after `CLKS_PER_BIT` clocks.
    - 1, no parity error: `data <= shift`, pulse `valid`, go to IDLE.
    - 1, with parity error: pulse `parity_err` (not `valid`), `data` unchanged, go to IDLE.
    - 0: pulse `frame_err`, `data` unchanged, go to BREAK.
  - **BREAK:** wait for `rxs == 1`, then go to IDLE. This prevents a held-low line from re-triggering starts.
- **Exclusivity.** `valid`, `frame_err` and `parity_err` are mutually exclusive.
- **Reset mid-frame.** Reset aborts the frame with no pulse and returns to IDLE. The next start is detected only on a fresh low after reset.

## Timing

- **Reset values:** `data = 8'h00`, `valid = 0`, `frame_err = 0`, `parity_err = 0`, `busy = 0`, state IDLE, synchroniser flops = 1.
- **Input latency:** a pin transition appears on `rxs` 2 edges later.
- **Reference edge:** t0 = the edge at which IDLE sees `rxs == 0`. `busy` is high from the cycle after t0.
- **Sample edges:**
  - start: t0 + HALF
  - data bit i: t0 + HALF + (i+1)·CLKS_PER_BIT
  - parity: t0 + HALF + 9·CLKS_PER_BIT
  - stop: one bit period after the last data or parity sample
- **Output pulse:** `valid`, `frame_err` or `parity_err` is high in the cycle after the stop sample. `busy` falls in the same cycle (except when going to BREAK). `data` updates in the same cycle as `valid`.
- **Back-to-back frames:** a start bit immediately following the stop bit is accepted. IDLE is re-entered within 1 cycle of the stop sample, well inside the stop bit's second half.

## Configuration

- **`UART_RX_PARITY_EN` defined:** 8-E-1 framing. The PARITY state and the `parity_err` port exist. Even parity means the data bits plus the parity bit contain an even number of ones.
- **Undefined:** 8-N-1 framing. No PARITY state and no `parity_err` port. STOP directly follows data bit 7.

## Test plan

Run all scenarios with `CLKS_PER_BIT = 16`.

1. **Single good byte.** Drive frame 0xA5 at 16 clk/bit → exactly one `valid` pulse, `data = 8'hA5`, `frame_err = 0`. Pulse lands at the edge after t0 + 8 + 144.
2. **Glitch.** Drive `rx` low for 4 clocks, then idle → no `valid`/`frame_err`. `busy` drops after the start sample; `data` unchanged.
3. **Bad stop bit.** Frame 0x3C with stop bit 0 and the line held low for 40 clocks → one `frame_err` pulse, `data` keeps its previous value, `busy` stays high until `rx` returns high, no new start is detected while low.
4. **Back-to-back with clock skew.** Frames 0x00 then 0xFF with zero idle gap, bit period 17 clk (+6% skew) → two `valid` pulses with `data` 8'h00 then 8'hFF.
5. **Reset mid-frame.** Assert reset during data bit 3 of 0x5A, then send 0x81 → no pulse for 0x5A. After reset `data = 8'h00`, then `valid` with `data = 8'h81`.
6. **Parity (`UART_RX_PARITY_EN` only).** Send 0x07 with parity bit 1 → `valid`, `data = 8'h07`. Send 0x07 with parity bit 0 → `parity_err` pulse, no `valid`, `data` stays 8'h07.
